db6_filter_bank: RTL

DB6_FILTER_BANK -- requirements
Module: db6_filter_bank

---
 rtl/db6_filter_bank_pkg.sv | 29 ++
 rtl/db6_filter_bank_if.sv | 35 +++
 rtl/db6_filter_bank_round_sat.sv | 37 +++
 rtl/db6_filter_bank.sv | 90 +++++++++
 4 files changed

// File: rtl/db6_filter_bank_pkg.sv
// db6_pkg: shared constants for the db6 filter bank.
//   H1/HZ1/HZ2     : branch indices (low-pass, high-pass 1, high-pass 2)
//   DEF_COEF       : reset-time coefficients for taps 0..5 of each branch
//   def_coef()     : default coefficient lookup, 0 beyond the table
//   acc_width()    : accumulator width that cannot overflow for a TAPS-long sum
package db6_pkg;

  localparam int H1      = 0;
  localparam int HZ1     = 1;
  localparam int HZ2     = 2;
  localparam int NBRANCH = 3;
  localparam int NDEF    = 6;

  localparam int DEF_COEF [NBRANCH][NDEF] = '{
    '{ 4,  8,  4,  4,  8,  4},
    '{ 1,  1, -2, -2,  1,  1},
    '{-1, -3, -2,  2,  3,  1}
  };

  function automatic int def_coef(input int branch, input int tap);
    if (branch < 0 || branch >= NBRANCH || tap < 0 || tap >= NDEF) return 0;
    return DEF_COEF[branch[1:0]][tap[2:0]];
  endfunction

  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/db6_filter_bank_if.sv
// db6_filter_bank_if: sample stream, result stream and coefficient write port.
//   in_data/in_valid/in_ready         : input sample handshake
//   out0/out1/out2/out_valid/out_ready: h1, hz1, hz2 results handshake
//   cfg_we/cfg_branch/cfg_tap/cfg_coef: coefficient write
// master = stimulus side, slave = filter bank.
interface db6_filter_bank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 6
);
  localparam int TW = $clog2(TAPS);

  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] out0;
  logic signed [DATA_WIDTH-1:0] out1;
  logic signed [DATA_WIDTH-1:0] out2;
  logic                         out_valid;
  logic                         out_ready;
  logic                         cfg_we;
  logic [1:0]                   cfg_branch;
  logic [TW-1:0]                cfg_tap;
  logic signed [COEF_WIDTH-1:0] cfg_coef;

  modport master (
    output in_data, in_valid, out_ready, cfg_we, cfg_branch, cfg_tap, cfg_coef,
    input  in_ready, out0, out1, out2, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready, cfg_we, cfg_branch, cfg_tap, cfg_coef,
    output in_ready, out0, out1, out2, out_valid
  );
endinterface

// File: rtl/db6_filter_bank_round_sat.sv
// db6_round_sat: combinational round-half-up, arithmetic shift and saturation.
//   acc  : full-precision signed branch sum (ACC_WIDTH)
//   dout : (acc + 2^(SHIFT-1)) >>> SHIFT clamped to the signed DATA_WIDTH range
module db6_round_sat #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 35,
  parameter int SHIFT      = 5
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] dout
);
  // One guard bit so the rounding add can never wrap.
  localparam int EW = ACC_WIDTH + 1;
  localparam logic signed [EW-1:0] MAXV = {{(EW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] shr;

  assign ext = {acc[ACC_WIDTH-1], acc};

  if (SHIFT == 0) begin : g_noround
    assign rnd = ext;
  end else begin : g_round
    localparam logic signed [EW-1:0] HALF = EW'(1) << (SHIFT - 1);
    assign rnd = ext + HALF;
  end

  assign shr = rnd >>> SHIFT;

  always_comb begin
    if (shr > MAXV)      dout = MAXV[DATA_WIDTH-1:0];
    else if (shr < MINV) dout = MINV[DATA_WIDTH-1:0];
    else                 dout = shr[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/db6_filter_bank.sv
// db6_filter_bank: three-branch FIR bank (h1, hz1, hz2) on one shared delay line.
//   clk, rst : clock, synchronous active-high reset
//   bus      : db6_filter_bank_if.slave (sample in, results out, coef writes)
// Pipeline: accept edge loads the delay line, next edge registers full sums,
// the edge after registers rounded/saturated outputs with out_valid.
// The whole pipeline freezes while a result is waiting on out_ready.
module db6_filter_bank
  import db6_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 6,
  parameter int SHIFT      = 5,
  parameter int DECIM      = 1
) (
  input logic               clk,
  input logic               rst,
  db6_filter_bank_if.slave  bus
);
  localparam int ACC_W = acc_width(DATA_WIDTH, COEF_WIDTH, TAPS);

  logic signed [DATA_WIDTH-1:0] dline [TAPS];
  logic signed [COEF_WIDTH-1:0] coef  [NBRANCH][TAPS];
  logic signed [ACC_W-1:0]      acc_c [NBRANCH];
  logic signed [ACC_W-1:0]      acc_q [NBRANCH];
  logic signed [DATA_WIDTH-1:0] rs    [NBRANCH];
  logic signed [DATA_WIDTH-1:0] out_q [NBRANCH];
  logic dl_valid, acc_valid, out_valid_q, phase;
  logic stall, accept;

  assign stall         = out_valid_q & ~bus.out_ready;
  assign accept        = bus.in_valid & ~stall;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out0      = out_q[H1];
  assign bus.out1      = out_q[HZ1];
  assign bus.out2      = out_q[HZ2];

  always_comb begin
    for (int b = 0; b < NBRANCH; b++) begin
      acc_c[b] = '0;
      for (int t = 0; t < TAPS; t++)
        acc_c[b] = acc_c[b] + ACC_W'(dline[t]) * ACC_W'(coef[b][t]);
    end
  end

  for (genvar b = 0; b < NBRANCH; b++) begin : g_rs
    db6_round_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_W),
      .SHIFT      (SHIFT)
    ) u_rs (
      .acc  (acc_q[b]),
      .dout (rs[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) dline[t] <= '0;
      for (int b = 0; b < NBRANCH; b++) begin
        acc_q[b] <= '0;
        out_q[b] <= '0;
        for (int t = 0; t < TAPS; t++) coef[b][t] <= COEF_WIDTH'(def_coef(b, t));
      end
      dl_valid    <= 1'b0;
      acc_valid   <= 1'b0;
      out_valid_q <= 1'b0;
      phase       <= 1'b0;
    end else begin
      // Coefficient writes land even during a stall; sums already registered keep old values.
      if (bus.cfg_we && bus.cfg_branch != 2'd3 && int'(bus.cfg_tap) < TAPS)
        coef[bus.cfg_branch][bus.cfg_tap] <= bus.cfg_coef;
      if (!stall) begin
        if (accept) begin
          dline[0] <= bus.in_data;
          for (int t = 1; t < TAPS; t++) dline[t] <= dline[t-1];
          if (DECIM == 2) phase <= ~phase;
        end
        // With DECIM=2 only every second accepted sample produces a result.
        dl_valid  <= accept & ((DECIM == 1) | phase);
        acc_valid <= dl_valid;
        for (int b = 0; b < NBRANCH; b++) acc_q[b] <= acc_c[b];
        if (acc_valid)
          for (int b = 0; b < NBRANCH; b++) out_q[b] <= rs[b];
        out_valid_q <= acc_valid;
      end
    end
  end
endmodule
